// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch control path.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SLOW   = 2'd0,
        NORMAL = 2'd1,
        FAST   = 2'd2
    } rate_t;

    localparam int ERR_CODE  = 1;
    localparam int DIGIT_MAX = 59;

    // Prescaler terminal value for a given rate; the unused encoding falls back to FAST.
    function automatic int unsigned rate_term(rate_t r, int unsigned base_div);
        case (r)
            SLOW:    return 2 * base_div - 1;
            NORMAL:  return base_div - 1;
            default: return base_div / 4 - 1;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_run_ctrl_if.sv
// Button inputs, datapath status and control strobes between board top and run control.
interface stopwatch_run_ctrl_if;
    import stopwatch_pkg::*;

    logic   start;
    logic   clear;
    logic   up;
    logic   plus_min2;
    logic   speedup;
    logic   slowdown;
    logic   count_zero;
    logic   count_max;
    logic   tick_en;
    logic   dir_up;
    logic   load_plus2;
    logic   clear_cnt;
    logic   err1;
    state_t state;

    modport master (
        output start, clear, up, plus_min2, speedup, slowdown, count_zero, count_max,
        input  tick_en, dir_up, load_plus2, clear_cnt, err1, state
    );

    modport slave (
        input  start, clear, up, plus_min2, speedup, slowdown, count_zero, count_max,
        output tick_en, dir_up, load_plus2, clear_cnt, err1, state
    );

endinterface

// File: rtl/tick_prescaler.sv
// Rate-selectable prescaler; period is high in the cycle the count sits at its terminal value.
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int unsigned BASE_DIV = 50_000_000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic  in_clk,
    input  logic  reset,
    input  logic  en,
    input  rate_t rate,
    input  logic  restart,
    output logic  period
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term;

    always_comb term = CNT_W'(rate_term(rate, BASE_DIV));

    assign period = en & (cnt == term);

    // restart wins over counting so a new rate always starts a full period
    always_ff @(posedge in_clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= period ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Run-control FSM for the MM:SS counter chain: button edges, rate, count-enable tick, terminal counts.
module stopwatch_run_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned BASE_DIV = 50_000_000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic                in_clk,
    input  logic                reset,
    stopwatch_run_ctrl_if.slave bus
);

    logic   start_q, clear_q, plus_q, speed_q, slow_q;
    logic   start_rise, clear_rise, plus_rise, speed_rise, slow_rise;
    logic   rate_inc, rate_dec, rate_chg;
    logic   term, zero_down, go_run, restart, period;
    rate_t  rate;
    state_t st;
    logic   tick_en, dir_up, load_plus2, clear_cnt, err1;

    assign start_rise = bus.start     & ~start_q;
    assign clear_rise = bus.clear     & ~clear_q;
    assign plus_rise  = bus.plus_min2 & ~plus_q;
    assign speed_rise = bus.speedup   & ~speed_q;
    assign slow_rise  = bus.slowdown  & ~slow_q;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            start_q <= 1'b0;
            clear_q <= 1'b0;
            plus_q  <= 1'b0;
            speed_q <= 1'b0;
            slow_q  <= 1'b0;
        end else begin
            start_q <= bus.start;
            clear_q <= bus.clear;
            plus_q  <= bus.plus_min2;
            speed_q <= bus.speedup;
            slow_q  <= bus.slowdown;
        end
    end

    // Opposing steps in the same cycle cancel; both ends saturate.
    assign rate_inc = speed_rise & ~slow_rise & (rate != FAST);
    assign rate_dec = slow_rise & ~speed_rise & (rate != SLOW);
    assign rate_chg = rate_inc | rate_dec;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            rate <= NORMAL;
        end else if (rate_inc) begin
            rate <= rate_t'(rate + 2'd1);
        end else if (rate_dec) begin
            rate <= rate_t'(rate - 2'd1);
        end
    end

    assign term      = (dir_up & bus.count_max) | (~dir_up & bus.count_zero);
    assign zero_down = ~dir_up & bus.count_zero;
    assign go_run    = ~clear_rise & start_rise &
                       (((st == IDLE) & ~zero_down) | ((st == PAUSE) & ~term));
    assign restart   = go_run | rate_chg | clear_rise;

    tick_prescaler #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) u_presc (
        .in_clk  (in_clk),
        .reset   (reset),
        .en      (st == RUN),
        .rate    (rate),
        .restart (restart),
        .period  (period)
    );

    always_ff @(posedge in_clk) begin
        if (reset) begin
            st         <= IDLE;
            tick_en    <= 1'b0;
            load_plus2 <= 1'b0;
            clear_cnt  <= 1'b0;
            err1       <= 1'b0;
            dir_up     <= 1'b1;
        end else begin
            tick_en    <= 1'b0;
            load_plus2 <= 1'b0;
            clear_cnt  <= 1'b0;
            if (st != RUN) dir_up <= bus.up;

            if (clear_rise) begin
                st        <= IDLE;
                clear_cnt <= 1'b1;
                err1      <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        if (start_rise) begin
                            if (zero_down) begin
                                st   <= ERR;
                                err1 <= 1'(ERR_CODE);
                            end else begin
                                st <= RUN;
                            end
                        end else if (plus_rise) begin
                            load_plus2 <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (start_rise) begin
                            st <= PAUSE;
                        end else if (period) begin
                            if (term) st <= DONE;
                            else      tick_en <= 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (start_rise) begin
                            st <= term ? DONE : RUN;
                        end else if (plus_rise) begin
                            load_plus2 <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (plus_rise) begin
                            load_plus2 <= 1'b1;
                            st         <= PAUSE;
                        end
                    end
                    ERR: begin
                        err1 <= 1'(ERR_CODE);
                        if (bus.up) begin
                            st   <= IDLE;
                            err1 <= 1'b0;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign bus.tick_en    = tick_en;
    assign bus.dir_up     = dir_up;
    assign bus.load_plus2 = load_plus2;
    assign bus.clear_cnt  = clear_cnt;
    assign bus.err1       = err1;
    assign bus.state      = st;

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Directed bench for stopwatch_run_ctrl at BASE_DIV=8; expected values are hand-computed.
module tb_stopwatch_run_ctrl;

    logic in_clk;
    logic reset;
    int   total;
    int   bad;

    stopwatch_run_ctrl_if bus ();

    stopwatch_run_ctrl #(
        .BASE_DIV (8),
        .CNT_W    (5)
    ) dut (
        .in_clk (in_clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.clear      = 1'b0;
        bus.up         = 1'b1;
        bus.plus_min2  = 1'b0;
        bus.speedup    = 1'b0;
        bus.slowdown   = 1'b0;
        bus.count_zero = 1'b0;
        bus.count_max  = 1'b0;

        // reset state
        step();
        step();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_dir", 32'(bus.dir_up), 32'd1);
        chk("rst_tick", 32'(bus.tick_en), 32'd0);
        chk("rst_err", 32'(bus.err1), 32'd0);
        reset = 1'b0;
        step();

        // start at NORMAL: ticks at +9, +17, +25
        bus.start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            step();
            if (c == 2) bus.start = 1'b0;
            chk("run_tick", 32'(bus.tick_en), 32'(c == 9 || c == 17 || c == 25));
        end
        chk("run_state", 32'(bus.state), 32'd1);

        // FAST: restart then every 2 cycles
        bus.speedup = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) bus.speedup = 1'b0;
            chk("fast_tick", 32'(bus.tick_en), 32'(c == 3 || c == 5 || c == 7));
        end
        // saturated speedup: no restart, cadence continues
        bus.speedup = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) bus.speedup = 1'b0;
            chk("sat_tick", 32'(bus.tick_en), 32'(c == 1 || c == 3 || c == 5));
        end
        // back to NORMAL: restart, every 8
        bus.slowdown = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            step();
            if (c == 1) bus.slowdown = 1'b0;
            chk("norm_tick", 32'(bus.tick_en), 32'(c == 9 || c == 17));
        end

        // terminal count up -> DONE, no tick
        bus.count_max = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            chk("tc_notick", 32'(bus.tick_en), 32'd0);
            if (c == 7) chk("tc_run", 32'(bus.state), 32'd1);
            if (c == 9) chk("tc_done", 32'(bus.state), 32'd3);
        end
        bus.start = 1'b1;
        step();
        step();
        chk("done_start_ign", 32'(bus.state), 32'd3);
        bus.start = 1'b0;
        step();
        bus.plus_min2 = 1'b1;
        step();
        chk("done_p2_pulse", 32'(bus.load_plus2), 32'd1);
        chk("done_p2_state", 32'(bus.state), 32'd2);
        chk("done_p2_clr", 32'(bus.clear_cnt), 32'd0);
        bus.plus_min2 = 1'b0;
        step();
        chk("p2_one_shot", 32'(bus.load_plus2), 32'd0);
        bus.count_max = 1'b0;

        // clear to IDLE, then +2 in IDLE
        bus.clear = 1'b1;
        step();
        chk("clr_pulse", 32'(bus.clear_cnt), 32'd1);
        chk("clr_state", 32'(bus.state), 32'd0);
        bus.clear = 1'b0;
        step();
        chk("clr_one_shot", 32'(bus.clear_cnt), 32'd0);
        bus.plus_min2 = 1'b1;
        step();
        chk("idle_p2", 32'(bus.load_plus2), 32'd1);
        chk("idle_p2_state", 32'(bus.state), 32'd0);
        bus.plus_min2 = 1'b0;
        step();

        // down-count start at 00:00 -> ERR
        bus.up         = 1'b0;
        bus.count_zero = 1'b1;
        step();
        step();
        bus.start = 1'b1;
        step();
        chk("err_state", 32'(bus.state), 32'd4);
        chk("err_flag", 32'(bus.err1), 32'd1);
        chk("err_tick", 32'(bus.tick_en), 32'd0);
        bus.start = 1'b0;
        step();
        step();
        chk("err_hold", 32'(bus.state), 32'd4);
        chk("err_hold_flag", 32'(bus.err1), 32'd1);
        bus.up = 1'b1;
        step();
        chk("err_exit", 32'(bus.state), 32'd0);
        chk("err_exit_flag", 32'(bus.err1), 32'd0);
        bus.count_zero = 1'b0;

        // direction frozen in RUN, follows in PAUSE; clear beats start and +2
        bus.start = 1'b1;
        step();
        chk("d_run", 32'(bus.state), 32'd1);
        bus.start = 1'b0;
        bus.up    = 1'b0;
        step();
        step();
        chk("d_frozen", 32'(bus.dir_up), 32'd1);
        bus.start = 1'b1;
        step();
        chk("d_pause", 32'(bus.state), 32'd2);
        chk("d_still", 32'(bus.dir_up), 32'd1);
        bus.start = 1'b0;
        step();
        chk("d_follow", 32'(bus.dir_up), 32'd0);
        bus.start     = 1'b1;
        bus.clear     = 1'b1;
        bus.plus_min2 = 1'b1;
        step();
        chk("all3_clr", 32'(bus.clear_cnt), 32'd1);
        chk("all3_p2", 32'(bus.load_plus2), 32'd0);
        chk("all3_state", 32'(bus.state), 32'd0);
        bus.start     = 1'b0;
        bus.clear     = 1'b0;
        bus.plus_min2 = 1'b0;
        bus.up        = 1'b1;
        step();
        chk("all3_one_shot", 32'(bus.clear_cnt), 32'd0);

        // reset mid-RUN at SLOW with prescaler at 5
        bus.slowdown = 1'b1;
        step();
        bus.slowdown = 1'b0;
        step();
        bus.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) bus.start = 1'b0;
            if (c == 2) bus.up = 1'b0;
        end
        reset = 1'b1;
        step();
        chk("mr_state", 32'(bus.state), 32'd0);
        chk("mr_tick", 32'(bus.tick_en), 32'd0);
        chk("mr_dir", 32'(bus.dir_up), 32'd1);
        chk("mr_err", 32'(bus.err1), 32'd0);
        chk("mr_p2", 32'(bus.load_plus2), 32'd0);
        chk("mr_clr", 32'(bus.clear_cnt), 32'd0);
        reset  = 1'b0;
        bus.up = 1'b1;
        step();
        step();
        bus.start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1) bus.start = 1'b0;
            chk("mr_restart_tick", 32'(bus.tick_en), 32'(c == 9));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_run_ctrl.md
Name: stopwatch_run_ctrl

Overview:
- Control FSM that sequences the four-digit MM:SS stopwatch counter chain.
- Converts the start, clear, direction, +2-minute and speed buttons into the datapath's control strobes.
- Generates the one-second count-enable tick from the board clock, detects terminal counts (59:59 up, 00:00 down) and raises error code 1.
- Sits between the board-level top and the S0/S1/M0/M1 digit blocks. It replaces the ad-hoc direction flop and the free-running clock divider with a single clock-enable scheme.

Parameters:
- BASE_DIV, 50_000_000: in_clk cycles per tick at normal speed (must be ≥ 8 and divisible by 4).
- CNT_W, 27: prescaler width (must satisfy 2^CNT_W > 2*BASE_DIV).

Ports:
- in_clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: start/stop toggle (level, already synchronised); acts on its rising edge.
- clear, input, 1: clear request (level); acts on its rising edge.
- up, input, 1: direction select, 1 = count up.
- plus_min2, input, 1: add-2-minutes request; acts on its rising edge.
- speedup, input, 1: rate step up; acts on its rising edge.
- slowdown, input, 1: rate step down; acts on its rising edge.
- count_zero, input, 1: datapath reads 00:00.
- count_max, input, 1: datapath reads 59:59.
- tick_en, output, 1: one-cycle count enable to the digit blocks.
- dir_up, output, 1: latched direction to the digit blocks.
- load_plus2, output, 1: one-cycle pulse; datapath adds 2 to MM.
- clear_cnt, output, 1: one-cycle pulse; datapath loads 00:00.
- err1, output, 1: error code 1 (down-count started at 00:00).
- state, output, 3: FSM state for debug and display.

Behaviour:
- Reset: on in_clk rising with reset=1, all registers take these values:
  - state=IDLE, tick_en=0, load_plus2=0, clear_cnt=0, err1=0, dir_up=1.
  - rate=NORMAL, prescaler=0, all edge-detect history regs=0.
  - Reset overrides every other input, including mid-RUN.
- Edge detect: x_rise = x & ~x_q, with x_q registered each cycle. A held button produces exactly one event.
- States (encoding, shared package):
  - IDLE=0, RUN=1, PAUSE=2, DONE=3, ERR=4.
- Direction:
  - dir_up <= up every cycle when state != RUN.
  - Frozen while in RUN.
- Rate: 2-bit index, SLOW=0 / NORMAL=1 / FAST=2.
  - speedup_rise increments; slowdown_rise decrements; both saturate.
  - Both rising in the same cycle: no change.
  - Terminal value: SLOW = 2*BASE_DIV-1, NORMAL = BASE_DIV-1, FAST = BASE_DIV/4-1.
- Prescaler: counts only in RUN.
  - Cleared on entry to RUN and on any rate change.
  - At the terminal value it wraps to 0 and a "period" event occurs.
- tick_en: registered output, asserted the cycle after the period event, only if no terminal count applies.
  - Terminal count means (dir_up & count_max) or (~dir_up & count_zero).
  - If a terminal count applies, no tick is issued and the FSM goes to DONE.
  - Latency: first tick_en = terminal value + 2 cycles after the start_rise cycle.
- clear_rise (highest priority after reset):
  - Any state -> IDLE, clear_cnt=1 for one cycle, err1<=0, prescaler=0.
- IDLE:
  - start_rise with ~dir_up & count_zero -> ERR, err1<=1.
  - Otherwise start_rise -> RUN.
  - plus_min2_rise -> load_plus2 pulse, stay in IDLE.
- RUN:
  - start_rise -> PAUSE (prescaler holds its value).
  - plus_min2_rise is ignored.
  - Terminal count at a period event -> DONE.
- PAUSE:
  - start_rise -> RUN, unless a terminal count holds, in which case -> DONE.
  - plus_min2_rise -> load_plus2 pulse.
- DONE:
  - start_rise is ignored.
  - plus_min2_rise -> load_plus2 pulse and -> PAUSE.
- ERR:
  - err1 held at 1.
  - up=1 for one cycle or clear_rise -> IDLE, err1<=0.
  - All other events are ignored.
- Simultaneous events in one cycle:
  - clear beats start and plus_min2.
  - start beats plus_min2; a plus_min2 event dropped this way is lost, not queued.
- Pulse rules:
  - load_plus2 and clear_cnt are never asserted together.
  - tick_en is never asserted in the same cycle as load_plus2 or clear_cnt.
- Saturation of MM+2 beyond 59 is the datapath's concern, not this block's.

Decomposition:
- Package stopwatch_pkg holds:
  - the state_t enum (3-bit);
  - the rate_t enum (SLOW, NORMAL, FAST);
  - localparams for the ERR code value (1) and the digit limits (59).
- One sub-module, tick_prescaler:
  - inputs: in_clk, reset, en, rate, restart;
  - output: period pulse.
- The FSM and the edge detectors stay in stopwatch_run_ctrl.

Test Plan:
- All tests use BASE_DIV=8. After reset, check state=0 and dir_up=1. Then start pulse, up=1, count_max=0 -> tick_en high at cycles 9, 17 and 25 after the start edge; state=1.
- Set rate=FAST via speedup, then speedup again -> rate saturates; ticks arrive every 2 cycles. One slowdown -> ticks every 8 cycles; prescaler restarts on each rate change.
- In RUN with up=1, raise count_max -> next period event gives no tick_en, state=3. A following start_rise is ignored. plus_min2 pulse -> one load_plus2 and state=2.
- In IDLE with up=0 and count_zero=1, pulse start -> state=4 and err1=1, no tick_en. Set up=1 -> state=0 and err1=0.
- In RUN, toggle up -> dir_up unchanged. Start pulse -> PAUSE, dir_up follows up next cycle. Start, clear and plus_min2 all in one cycle -> only clear_cnt pulses, state=0.
- Assert reset mid-RUN with the prescaler at 5 -> next cycle all outputs are at reset values. The next start gives its first tick 9 cycles after the start edge.
